uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Upstream stage of the command FIFO. Consumes the UART RX byte stream and parses host frames of the form SYNC(0xA5), HDR, LEN, then LEN payload bytes. Payload bytes go to the payload FIFO; once the frame is complete, one {instr, payload_len} entry goes to the command FIFO. Admission control guarantees the two FIFOs never disagree: every command entry is backed by exactly len payload bytes.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 16'd50000, inter-byte timeout in clk cycles, must be >= 2
PL_DEPTH, 256, payload FIFO depth; a len above this is rejected

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_valid  in  1  RX byte available
rx_data  in  8  RX byte
rx_ready  out  1  parser accepts byte; transfer = rx_valid & rx_ready
cmd_wr_en  out  1  command FIFO write strobe
cmd_instr  out  4  command FIFO instr
cmd_len  out  8  command FIFO payload_len
cmd_full  in  1  command FIFO full
pl_wr_en  out  1  payload FIFO write strobe
pl_data  out  8  payload byte
pl_free  in  9  payload FIFO free entries
err_valid  out  1  one-cycle error pulse
err_code  out  3  error cause, valid with err_valid
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - state=IDLE.
  - All strobes are 0; cmd_instr, cmd_len, pl_data and err_code are 0.
  - Timeout counter is 0.
  - rx_ready is 1 combinationally in IDLE.
  - Reset mid-frame drops the frame with no further FIFO writes.
- rx_ready is combinational from state: 1 in IDLE, HDR, LEN, PAYLOAD, SKIP; 0 in WAIT_SPACE, PAD, COMMIT.
- All FIFO and error outputs are registered. A write strobe asserts the cycle after the causing transfer or state and lasts exactly 1 cycle.
- States:
  - IDLE: on a transfer with SYNC_BYTE, go to HDR. Any other byte is discarded silently.
  - HDR: on a transfer, latch instr=rx_data[7:4]; bits [3:0] are reserved and ignored. Go to LEN.
  - LEN: on a transfer, latch len.
    - instr==4'hF (reserved DISCARD): err 2, go to SKIP.
    - len>PL_DEPTH: err 4, go to SKIP.
    - Otherwise go to WAIT_SPACE.
  - WAIT_SPACE: stay while cmd_full==1 or {1'b0,len}>pl_free.
    - When space exists and len==0, go to COMMIT.
    - When space exists and len>0, go to PAYLOAD with remaining=len.
  - PAYLOAD: on each transfer, pl_wr_en<=1, pl_data<=rx_data, remaining-=1. After the transfer that brings remaining to 0, go to COMMIT.
  - COMMIT: cmd_wr_en<=1, cmd_instr<=instr, cmd_len<=len; go to IDLE. Exactly one cycle.
  - SKIP: consume and drop remaining=len bytes with no writes, then go to IDLE. len==0 goes to IDLE immediately.
  - PAD: one zero byte per cycle (pl_wr_en<=1, pl_data<=0) until remaining==0. Then COMMIT with instr forced to 4'hF and the original len, so the downstream stage drains and ignores the payload.
- Timeout counter:
  - Counts in HDR, LEN, PAYLOAD and SKIP; clears on every transfer and on every state change.
  - Does not count in IDLE, WAIT_SPACE, PAD or COMMIT.
  - Fires when the count reaches TIMEOUT-1 with no transfer in that cycle.
  - HDR, LEN or SKIP: err 1, go to IDLE.
  - PAYLOAD: err 3, go to PAD. Bytes already written stay written.
- Error codes: 1 header timeout, 2 illegal instr, 3 payload timeout/padded, 4 len exceeds PL_DEPTH.
  - err_valid is asserted one cycle after the triggering event.
- Admission assumption: this block is the only payload and command FIFO writer, so free space can only grow while waiting.
  - pl_free lags a write by one cycle. At least 3 byte transfers (SYNC, HDR, LEN) separate any COMMIT from the next WAIT_SPACE, so the sampled value is always current.
- Widths: remaining is 9 bits, so len=255 and PL_DEPTH=256 fit; len is compared zero-extended.

Decomposition:
- Package uart_bridge_pkg:
  - parser_state_e enum.
  - SYNC_BYTE default.
  - INSTR_DISCARD=4'hF.
  - err_code_e, values 1..4.
- Timeout counter as sub-module byte_timeout, with inputs clk, rst, enable, clear and output expired. It is reused by the JTAG side.
- Everything else stays in one FSM module.

Test Plan:
- Nominal frame: bytes A5,30,03,11,22,33 with rx_valid held 1. Required: pl_wr_en pulses write 11,22,33; then one cmd_wr_en with instr=3, len=3; busy=0 afterwards.
- Zero-length frame and resync: bytes 00,7F,A5,50,00. The first two are dropped; one command with instr=5, len=0; no pl_wr_en.
- Backpressure: pl_free=2 with frame A5,10,04,... Required: parser holds in WAIT_SPACE with rx_ready=0. Raise pl_free to 4 and the 4 payload bytes plus the command complete. Repeat with cmd_full=1 and expect the same stall.
- Illegal frames:
  - A5,F0,02,AA,BB: err 2, no writes, next frame parses normally.
  - A5,10,FF with PL_DEPTH=128: err 4 and 255 bytes skipped.
- Payload timeout: TIMEOUT=16, frame A5,20,04,01,02, then idle. Required: err 3; payload writes 01,02,00,00; command with instr=F, len=4.
- Reset mid-PAYLOAD: assert rst after 1 payload byte. Required: all outputs 0 on the next cycle, no cmd_wr_en, next frame parses correctly.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bridge_pkg
//  Description : Shared types and constants for the UART command bridge.
//                Parser state encoding, error cause codes, frame constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

    localparam logic [7:0] C_SYNC_BYTE_DEFAULT = 8'hA5;
    // Reserved instruction: downstream drains and ignores the payload.
    localparam logic [3:0] C_INSTR_DISCARD     = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HDR        = 3'd1,
        ST_LEN        = 3'd2,
        ST_WAIT_SPACE = 3'd3,
        ST_PAYLOAD    = 3'd4,
        ST_COMMIT     = 3'd5,
        ST_SKIP       = 3'd6,
        ST_PAD        = 3'd7
    } parser_state_e;

    typedef enum logic [2:0] {
        ERR_NONE            = 3'd0,
        ERR_HDR_TIMEOUT     = 3'd1,
        ERR_ILLEGAL_INSTR   = 3'd2,
        ERR_PAYLOAD_TIMEOUT = 3'd3,
        ERR_LEN_TOO_BIG     = 3'd4
    } err_code_e;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser_if
//  Description : Bundles the RX byte stream, the command/payload FIFO write
//                ports and the error/status outputs of the command parser.
//                master : parser side (drives rx_ready, FIFO writes, errors)
//                slave  : environment side (drives RX bytes, FIFO status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_parser_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       cmd_wr_en;
    logic [3:0] cmd_instr;
    logic [7:0] cmd_len;
    logic       cmd_full;
    logic       pl_wr_en;
    logic [7:0] pl_data;
    logic [8:0] pl_free;
    logic       err_valid;
    logic [2:0] err_code;
    logic       busy;

    modport master (
        input  rx_valid, rx_data, cmd_full, pl_free,
        output rx_ready, cmd_wr_en, cmd_instr, cmd_len,
               pl_wr_en, pl_data, err_valid, err_code, busy
    );

    modport slave (
        output rx_valid, rx_data, cmd_full, pl_free,
        input  rx_ready, cmd_wr_en, cmd_instr, cmd_len,
               pl_wr_en, pl_data, err_valid, err_code, busy
    );
endinterface
`default_nettype wire

// File: rtl/byte_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : byte_timeout
//  Description : Inter-byte timeout counter. Counts while enable is high,
//                returns to zero on clear. expired is a combinational pulse
//                in the cycle the count sits at TIMEOUT-1 with no clear.
//  Ports       : clk, rst (sync, active-high), enable, clear -> expired
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_timeout #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic enable,
    input  wire logic clear,
    output logic      expired
);
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= 16'd0;
        end else if (enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign expired = enable && !clear && (r_count == TIMEOUT - 16'd1);
endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Parses SYNC/HDR/LEN/payload host frames from the UART RX
//                stream. Payload bytes are written to the payload FIFO and a
//                single {instr, len} entry to the command FIFO per frame.
//                Space for the whole frame is reserved before any payload
//                byte is accepted, so both FIFOs always stay consistent.
//  Ports       : clk, rst (sync, active-high), bus (uart_cmd_parser_if.master)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_bridge_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = C_SYNC_BYTE_DEFAULT,
    parameter logic [15:0] TIMEOUT   = 16'd50000,
    parameter int          PL_DEPTH  = 256
) (
    input  wire logic           clk,
    input  wire logic           rst,
    uart_cmd_parser_if.master   bus
);
    localparam logic [9:0] C_PL_DEPTH = 10'(PL_DEPTH);

    parser_state_e r_state;
    logic [3:0]    r_instr;
    logic [7:0]    r_len;
    logic [8:0]    r_rem;
    logic          r_cmd_wr_en;
    logic [3:0]    r_cmd_instr;
    logic [7:0]    r_cmd_len;
    logic          r_pl_wr_en;
    logic [7:0]    r_pl_data;
    logic          r_err_valid;
    err_code_e     r_err_code;

    logic w_rx_ready;
    logic w_xfer;
    logic w_tmo_en;
    logic w_tmo_clear;
    logic w_expired;

    assign w_rx_ready = !(r_state inside {ST_WAIT_SPACE, ST_PAD, ST_COMMIT});
    assign w_xfer     = bus.rx_valid && w_rx_ready;
    assign w_tmo_en   = r_state inside {ST_HDR, ST_LEN, ST_PAYLOAD, ST_SKIP};
    // Every entry into a counting state is either caused by a transfer or
    // comes from a non-counting state, so holding the counter at zero
    // outside the counting states covers the clear-on-state-change rule.
    assign w_tmo_clear = w_xfer || !w_tmo_en;

    byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_tmo_en),
        .clear   (w_tmo_clear),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_instr     <= 4'd0;
            r_len       <= 8'd0;
            r_rem       <= 9'd0;
            r_cmd_wr_en <= 1'b0;
            r_cmd_instr <= 4'd0;
            r_cmd_len   <= 8'd0;
            r_pl_wr_en  <= 1'b0;
            r_pl_data   <= 8'd0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_cmd_wr_en <= 1'b0;
            r_pl_wr_en  <= 1'b0;
            r_err_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && bus.rx_data == SYNC_BYTE) r_state <= ST_HDR;
                end
                ST_HDR: begin
                    if (w_xfer) begin
                        r_instr <= bus.rx_data[7:4];
                        r_state <= ST_LEN;
                    end else if (w_expired) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_HDR_TIMEOUT;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_LEN: begin
                    if (w_xfer) begin
                        r_len <= bus.rx_data;
                        r_rem <= {1'b0, bus.rx_data};
                        if (r_instr == C_INSTR_DISCARD ||
                            {2'b00, bus.rx_data} > C_PL_DEPTH) begin
                            r_err_valid <= 1'b1;
                            r_err_code  <= (r_instr == C_INSTR_DISCARD) ?
                                           ERR_ILLEGAL_INSTR : ERR_LEN_TOO_BIG;
                            // Nothing to skip for a zero-length frame.
                            r_state     <= (bus.rx_data == 8'd0) ? ST_IDLE : ST_SKIP;
                        end else begin
                            r_state <= ST_WAIT_SPACE;
                        end
                    end else if (w_expired) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_HDR_TIMEOUT;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WAIT_SPACE: begin
                    if (!bus.cmd_full && {1'b0, r_len} <= bus.pl_free) begin
                        r_state <= (r_len == 8'd0) ? ST_COMMIT : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        r_pl_wr_en <= 1'b1;
                        r_pl_data  <= bus.rx_data;
                        r_rem      <= r_rem - 9'd1;
                        if (r_rem == 9'd1) r_state <= ST_COMMIT;
                    end else if (w_expired) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_PAYLOAD_TIMEOUT;
                        // The padded frame is committed as DISCARD so the
                        // consumer still drains exactly len bytes.
                        r_instr     <= C_INSTR_DISCARD;
                        r_state     <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    r_pl_wr_en <= 1'b1;
                    r_pl_data  <= 8'd0;
                    r_rem      <= r_rem - 9'd1;
                    if (r_rem == 9'd1) r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_cmd_wr_en <= 1'b1;
                    r_cmd_instr <= r_instr;
                    r_cmd_len   <= r_len;
                    r_state     <= ST_IDLE;
                end
                ST_SKIP: begin
                    if (w_xfer) begin
                        r_rem <= r_rem - 9'd1;
                        if (r_rem == 9'd1) r_state <= ST_IDLE;
                    end else if (w_expired) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_HDR_TIMEOUT;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_ready  = w_rx_ready;
    assign bus.cmd_wr_en = r_cmd_wr_en;
    assign bus.cmd_instr = r_cmd_instr;
    assign bus.cmd_len   = r_cmd_len;
    assign bus.pl_wr_en  = r_pl_wr_en;
    assign bus.pl_data   = r_pl_data;
    assign bus.err_valid = r_err_valid;
    assign bus.err_code  = r_err_code;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_parser
//  Description : Self-checking bench for uart_cmd_parser. A byte-level frame
//                model predicts the ordered stream of payload writes, command
//                writes and error pulses; directed frames plus random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;
    import uart_bridge_pkg::*;

    localparam logic [15:0] TMO = 16'd16;
    localparam int          PLD = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TMO),
        .PL_DEPTH  (PLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct packed {
        logic [1:0] kind;   // 0 payload write, 1 command write, 2 error
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;

    int         obs_pl = 0, obs_cmd = 0, obs_err = 0;
    logic [7:0] last_pl = 8'd0;
    logic [3:0] last_instr = 4'd0;
    logic [7:0] last_len = 8'd0;
    logic [2:0] last_err = 3'd0;
    bit         rand_phase = 0;

    // ---------------- frame model (byte-level, no timing) ----------------
    int         m_phase = 0;    // 0 hunt, 1 hdr, 2 len, 3 payload, 4 skip
    logic [3:0] m_instr;
    logic [7:0] m_len;
    int         m_rem;

    function automatic void push(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        e.kind = k; e.a = a; e.b = b;
        expq.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] v);
        case (m_phase)
            0: if (v == 8'hA5) m_phase = 1;
            1: begin m_instr = v[7:4]; m_phase = 2; end
            2: begin
                m_len = v;
                m_rem = int'(v);
                if (m_instr == 4'hF || int'(v) > PLD) begin
                    push(2, (m_instr == 4'hF) ? 8'd2 : 8'd4, 8'd0);
                    m_phase = (v == 8'd0) ? 0 : 4;
                end else if (v == 8'd0) begin
                    push(1, {4'd0, m_instr}, 8'd0);
                    m_phase = 0;
                end else begin
                    m_phase = 3;
                end
            end
            3: begin
                push(0, v, 8'd0);
                m_rem--;
                if (m_rem == 0) begin push(1, {4'd0, m_instr}, m_len); m_phase = 0; end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_phase = 0;
            end
        endcase
    endfunction

    function automatic void model_timeout();
        if (m_phase == 3) begin
            push(2, 8'd3, 8'd0);
            for (int i = 0; i < m_rem; i++) push(0, 8'd0, 8'd0);
            push(1, 8'h0F, m_len);
        end else if (m_phase != 0) begin
            push(2, 8'd1, 8'd0);
        end
        m_phase = 0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic match(input string name, input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event a=%0h b=%0h, none expected", name, a, b);
        end else begin
            e = expq.pop_front();
            if (e.kind !== k || e.a !== a || e.b !== b) begin
                errors++;
                $display("FAIL %s: got kind=%0d a=%0h b=%0h expected kind=%0d a=%0h b=%0h",
                         name, k, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // Single compare process: every strobe must match the next modelled event.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pl_wr_en) begin
                obs_pl++; last_pl = bus.pl_data;
                match("pl_write", 2'd0, bus.pl_data, 8'd0);
            end
            if (bus.cmd_wr_en) begin
                obs_cmd++; last_instr = bus.cmd_instr; last_len = bus.cmd_len;
                match("cmd_write", 2'd1, {4'd0, bus.cmd_instr}, bus.cmd_len);
            end
            if (bus.err_valid) begin
                obs_err++; last_err = bus.err_code;
                match("err_pulse", 2'd2, {5'd0, bus.err_code}, 8'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] v);
        bit done = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = v;
        for (int i = 0; i < 400 && !done; i++) begin
            if (bus.rx_ready) done = 1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        if (done) model_byte(v);
        else begin
            checks++; errors++;
            $display("FAIL send_wait: byte %0h not accepted, expected acceptance within 400 cycles", v);
        end
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Random cmd_full activity during the random phase only.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_phase) bus.cmd_full = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, c0, e0, n;
        logic [7:0] v;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.cmd_full = 1'b0;
        bus.pl_free  = 9'd256;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rx_ready",  int'(bus.rx_ready), 1);
        check("rst_busy",      int'(bus.busy), 0);
        check("rst_pl_wr_en",  int'(bus.pl_wr_en), 0);
        check("rst_cmd_wr_en", int'(bus.cmd_wr_en), 0);
        check("rst_err_valid", int'(bus.err_valid), 0);
        check("rst_cmd_instr", int'(bus.cmd_instr), 0);
        check("rst_cmd_len",   int'(bus.cmd_len), 0);
        check("rst_pl_data",   int'(bus.pl_data), 0);
        check("rst_err_code",  int'(bus.err_code), 0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame
        p0 = obs_pl; c0 = obs_cmd;
        send(8'hA5); send(8'h30); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        idle(4);
        check("nom_pl_count", obs_pl - p0, 3);
        check("nom_last_pl",  int'(last_pl), 'h33);
        check("nom_cmd_count", obs_cmd - c0, 1);
        check("nom_instr", int'(last_instr), 3);
        check("nom_len",   int'(last_len), 3);
        check("nom_busy",  int'(bus.busy), 0);

        // Zero-length frame with leading garbage
        p0 = obs_pl; c0 = obs_cmd;
        send(8'h00); send(8'h7F); send(8'hA5); send(8'h50); send(8'h00);
        idle(4);
        check("zl_cmd_count", obs_cmd - c0, 1);
        check("zl_instr", int'(last_instr), 5);
        check("zl_len",   int'(last_len), 0);
        check("zl_pl_count", obs_pl - p0, 0);

        // Backpressure on payload space, then on command FIFO full
        for (int pass = 0; pass < 2; pass++) begin
            p0 = obs_pl; c0 = obs_cmd;
            if (pass == 0) bus.pl_free = 9'd2; else bus.cmd_full = 1'b1;
            send(8'hA5); send(8'h10); send(8'h04);
            idle(6);
            check("bp_rx_ready", int'(bus.rx_ready), 0);
            check("bp_busy", int'(bus.busy), 1);
            check("bp_no_cmd", obs_cmd - c0, 0);
            if (pass == 0) bus.pl_free = 9'd4; else bus.cmd_full = 1'b0;
            send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
            idle(4);
            check("bp_pl_count", obs_pl - p0, 4);
            check("bp_instr", int'(last_instr), 1);
            check("bp_len",   int'(last_len), 4);
            bus.pl_free = 9'd256;
        end

        // Illegal instruction, then a normal frame
        p0 = obs_pl; c0 = obs_cmd; e0 = obs_err;
        send(8'hA5); send(8'hF0); send(8'h02); send(8'hAA); send(8'hBB);
        idle(3);
        check("ill_err_count", obs_err - e0, 1);
        check("ill_err_code", int'(last_err), 2);
        check("ill_no_writes", (obs_pl - p0) + (obs_cmd - c0), 0);
        send(8'hA5); send(8'h40); send(8'h01); send(8'h5A);
        idle(4);
        check("ill_next_instr", int'(last_instr), 4);
        check("ill_next_len",   int'(last_len), 1);

        // Length above PL_DEPTH: 255 bytes skipped
        p0 = obs_pl; c0 = obs_cmd;
        send(8'hA5); send(8'h10); send(8'hFF);
        idle(2);
        check("big_err_code", int'(last_err), 4);
        for (int i = 0; i < 254; i++) send(8'($urandom));
        check("big_busy_mid", int'(bus.busy), 1);
        send(8'hA5);
        check("big_busy_end", int'(bus.busy), 0);
        check("big_no_writes", (obs_pl - p0) + (obs_cmd - c0), 0);

        // Header timeout
        send(8'hA5);
        model_timeout();
        idle(25);
        check("hdr_tmo_err", int'(last_err), 1);

        // Payload timeout: latency pinned, then zero padding and DISCARD commit
        p0 = obs_pl;
        send(8'hA5); send(8'h20); send(8'h04); send(8'h01); send(8'h02);
        model_timeout();
        n = 0;
        while (!bus.err_valid && n < 100) begin @(negedge clk); n++; end
        check("tmo_latency", n, 16);
        idle(6);
        check("tmo_err_code", int'(last_err), 3);
        check("tmo_pl_count", obs_pl - p0, 4);
        check("tmo_last_pl", int'(last_pl), 0);
        check("tmo_instr", int'(last_instr), 15);
        check("tmo_len",   int'(last_len), 4);

        // Reset in the middle of a payload
        c0 = obs_cmd;
        send(8'hA5); send(8'h60); send(8'h05); send(8'h77);
        idle(2);
        check("mid_rst_pending", expq.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pl_data", int'(bus.pl_data), 0);
        check("mid_rst_busy",    int'(bus.busy), 0);
        check("mid_rst_strobes", int'({bus.pl_wr_en, bus.cmd_wr_en, bus.err_valid}), 0);
        rst = 1'b0;
        m_phase = 0;
        idle(2);
        send(8'hA5); send(8'h70); send(8'h02); send(8'hAB); send(8'hCD);
        idle(4);
        check("mid_rst_cmds", obs_cmd - c0, 1);
        check("mid_rst_instr", int'(last_instr), 7);
        check("mid_rst_len",   int'(last_len), 2);

        // Random frames with junk, gaps and command FIFO backpressure
        rand_phase = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            int junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) begin
                v = 8'($urandom);
                if (v == 8'hA5) v = 8'h00;
                send(v);
                idle($urandom_range(0, 3));
            end
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(129, 140) : $urandom_range(0, 12);
            send(8'hA5);                                idle($urandom_range(0, 3));
            send({4'($urandom_range(0, 15)), 4'($urandom)}); idle($urandom_range(0, 3));
            send(8'(len));                              idle($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                send(8'($urandom));
                idle($urandom_range(0, 3));
            end
        end
        rand_phase = 0;
        bus.cmd_full = 1'b0;
        idle(40);
        check("final_queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
